// File: rtl/transpose_tile_sched.sv
// transpose_tile_sched: walks win x ch_slices in TOUT x TOUT tiles, issuing ping-pong read and write burst commands
module transpose_tile_sched #(
  parameter int TOUT = 32,
  parameter int PIX_BYTES = 32,
  parameter int DIM_W = 16,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DIM_W-1:0]  win,
  input  logic [DIM_W-1:0]  ch_slices,
  input  logic [ADDR_W-1:0] in_base,
  input  logic [ADDR_W-1:0] in_surface_stride,
  input  logic [ADDR_W-1:0] out_base,
  output logic              busy,
  output logic              done,
  output logic              rd_cmd_valid,
  input  logic              rd_cmd_ready,
  output logic [ADDR_W-1:0] rd_cmd_addr,
  output logic [7:0]        rd_cmd_len,
  output logic              rd_cmd_buf,
  input  logic              rd_tile_done,
  output logic              wr_cmd_valid,
  input  logic              wr_cmd_ready,
  output logic [ADDR_W-1:0] wr_cmd_addr,
  output logic [7:0]        wr_cmd_len,
  output logic              wr_cmd_buf,
  input  logic              wr_tile_done
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  localparam int CW = 2 * DIM_W;
  localparam logic [ADDR_W-1:0] TILE = ADDR_W'(TOUT * PIX_BYTES);
  localparam logic [DIM_W-1:0] TOUT_D = DIM_W'(TOUT);
  state_t state, state_nx;
  logic [DIM_W-1:0] ch_r, ci, rem;
  logic [ADDR_W-1:0] stride_r, col_base, rd_addr, wr_addr;
  logic [CW-1:0] rd_cnt, wr_done_cnt;
  logic [1:0] occ, rd_pend, filled, wr_pend;
  logic empty, rd_buf, wr_buf, rd_acc, wr_acc, rd_done_v, wr_done_v, ci_last, last_rd;

  assign rd_acc = rd_cmd_valid && rd_cmd_ready;
  assign wr_acc = wr_cmd_valid && wr_cmd_ready;
  // completion pulses with nothing outstanding are protocol errors and dropped
  assign rd_done_v = rd_tile_done && rd_pend != 2'd0 && state != IDLE;
  assign wr_done_v = wr_tile_done && wr_pend != 2'd0 && state != IDLE;
  assign ci_last = ci == ch_r - DIM_W'(1);
  assign last_rd = ci_last && rem <= TOUT_D;

  assign busy = state != IDLE;
  assign done = state == DONE;
  assign rd_cmd_valid = state == RUN && !empty && occ != 2'd2;
  assign rd_cmd_addr = rd_addr;
  assign rd_cmd_len = rem >= TOUT_D ? 8'(TOUT - 1) : 8'(rem - DIM_W'(1));
  assign rd_cmd_buf = rd_buf;
  assign wr_cmd_valid = state != IDLE && filled != 2'd0;
  assign wr_cmd_addr = wr_addr;
  assign wr_cmd_len = 8'(TOUT - 1);
  assign wr_cmd_buf = wr_buf;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  state_nx = start ? RUN : IDLE;
      RUN:   state_nx = empty ? DONE : (rd_acc && last_rd) ? DRAIN : RUN;
      DRAIN: state_nx = wr_done_cnt == rd_cnt ? DONE : DRAIN;
      DONE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ch_r <= '0;
      ci <= '0;
      rem <= '0;
      stride_r <= '0;
      col_base <= '0;
      rd_addr <= '0;
      wr_addr <= '0;
      rd_cnt <= '0;
      wr_done_cnt <= '0;
      occ <= '0;
      rd_pend <= '0;
      filled <= '0;
      wr_pend <= '0;
      empty <= 1'b0;
      rd_buf <= 1'b0;
      wr_buf <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE) begin
        if (start) begin
          ch_r <= ch_slices;
          ci <= '0;
          rem <= win;
          stride_r <= in_surface_stride;
          col_base <= in_base;
          rd_addr <= in_base;
          wr_addr <= out_base;
          rd_cnt <= '0;
          wr_done_cnt <= '0;
          occ <= '0;
          rd_pend <= '0;
          filled <= '0;
          wr_pend <= '0;
          empty <= win == '0 || ch_slices == '0;
          rd_buf <= 1'b0;
          wr_buf <= 1'b0;
        end
      end else begin
        // rem tracks win - co*TOUT so the short last column needs no multiplier
        if (rd_acc) begin
          rd_buf <= ~rd_buf;
          rd_cnt <= rd_cnt + CW'(1);
          ci <= ci_last ? '0 : ci + DIM_W'(1);
          rd_addr <= ci_last ? col_base + TILE : rd_addr + stride_r;
          if (ci_last) begin
            col_base <= col_base + TILE;
            rem <= rem - TOUT_D;
          end
        end
        if (wr_acc) begin
          wr_buf <= ~wr_buf;
          wr_addr <= wr_addr + TILE;
        end
        if (wr_done_v) wr_done_cnt <= wr_done_cnt + CW'(1);
        occ <= occ + 2'(rd_acc) - 2'(wr_done_v);
        rd_pend <= rd_pend + 2'(rd_acc) - 2'(rd_done_v);
        filled <= filled + 2'(rd_done_v) - 2'(wr_acc);
        wr_pend <= wr_pend + 2'(wr_acc) - 2'(wr_done_v);
      end
    end
  end
endmodule

// File: tb/tb_transpose_tile_sched.sv
// tb_transpose_tile_sched: table-driven jobs against a scoreboard of expected read/write commands
module tb_transpose_tile_sched;
  localparam int TOUT = 32, DW = 16, AW = 32, TB = 1024;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [DW-1:0] win = '0, ch_slices = '0;
  logic [AW-1:0] in_base = '0, in_surface_stride = '0, out_base = '0;
  logic busy, done, rd_cmd_valid, rd_cmd_buf, wr_cmd_valid, wr_cmd_buf;
  logic [AW-1:0] rd_cmd_addr, wr_cmd_addr;
  logic [7:0] rd_cmd_len, wr_cmd_len;
  logic rd_cmd_ready = 1'b0, rd_tile_done = 1'b0, wr_cmd_ready = 1'b0, wr_tile_done = 1'b0;

  transpose_tile_sched dut (
    .clk(clk), .rst(rst), .start(start), .win(win), .ch_slices(ch_slices),
    .in_base(in_base), .in_surface_stride(in_surface_stride), .out_base(out_base),
    .busy(busy), .done(done),
    .rd_cmd_valid(rd_cmd_valid), .rd_cmd_ready(rd_cmd_ready), .rd_cmd_addr(rd_cmd_addr),
    .rd_cmd_len(rd_cmd_len), .rd_cmd_buf(rd_cmd_buf), .rd_tile_done(rd_tile_done),
    .wr_cmd_valid(wr_cmd_valid), .wr_cmd_ready(wr_cmd_ready), .wr_cmd_addr(wr_cmd_addr),
    .wr_cmd_len(wr_cmd_len), .wr_cmd_buf(wr_cmd_buf), .wr_tile_done(wr_tile_done)
  );

  always #5 clk = ~clk;

  typedef struct {logic [AW-1:0] addr; logic [7:0] len; logic b;} cmd_t;
  typedef struct {int win; int ch; int stride; int ib; int ob; bit bp; int nt;} vec_t;

  cmd_t rd_q[$], wr_q[$];
  int rd_due[$], wr_due[$];
  logic [AW-1:0] rd_log[$];
  logic [7:0] len_log[$];
  int checks = 0, failures = 0, cyc = 0, n_rd = 0, n_wr = 0, n_done = 0, n_coinc = 0;
  bit bp = 0, hold_wr = 0;
  vec_t v[7];

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  // bus responder and command monitor, acting exactly on the falling edge
  initial forever begin
    @(negedge clk);
    cyc++;
    rd_cmd_ready = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
    wr_cmd_ready = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
    rd_tile_done = rd_due.size() > 0 && rd_due[0] <= cyc;
    if (rd_tile_done) void'(rd_due.pop_front());
    wr_tile_done = !hold_wr && wr_due.size() > 0 && wr_due[0] <= cyc;
    if (wr_tile_done) void'(wr_due.pop_front());
    if (done) n_done++;
    if (rd_cmd_valid) begin
      chk("rd_expected", rd_q.size() > 0, 1);
      if (rd_q.size() > 0) begin
        chk("rd_addr", rd_cmd_addr, rd_q[0].addr);
        chk("rd_len", rd_cmd_len, rd_q[0].len);
        chk("rd_buf", rd_cmd_buf, rd_q[0].b);
        if (rd_cmd_ready) begin
          rd_log.push_back(rd_cmd_addr);
          len_log.push_back(rd_cmd_len);
          void'(rd_q.pop_front());
          rd_due.push_back(cyc + 3);
          n_rd++;
          if (wr_tile_done) n_coinc++;
        end
      end
    end
    if (wr_cmd_valid) begin
      chk("wr_expected", wr_q.size() > 0, 1);
      if (wr_q.size() > 0) begin
        chk("wr_addr", wr_cmd_addr, wr_q[0].addr);
        chk("wr_len", wr_cmd_len, wr_q[0].len);
        chk("wr_buf", wr_cmd_buf, wr_q[0].b);
        if (wr_cmd_ready) begin
          void'(wr_q.pop_front());
          wr_due.push_back(cyc + 4);
          n_wr++;
        end
      end
    end
  end

  task automatic load(vec_t x);
    int t = 0;
    for (int co = 0; co * TOUT < x.win; co++)
      for (int ci = 0; ci < x.ch; ci++) begin
        int rows = x.win - co * TOUT;
        if (rows > TOUT) rows = TOUT;
        rd_q.push_back('{AW'(x.ib + ci * x.stride + co * TB), 8'(rows - 1), t[0]});
        wr_q.push_back('{AW'(x.ob + t * TB), 8'(TOUT - 1), t[0]});
        t++;
      end
  endtask

  task automatic launch(vec_t x);
    bp = x.bp;
    win = DW'(x.win);
    ch_slices = DW'(x.ch);
    in_base = AW'(x.ib);
    in_surface_stride = AW'(x.stride);
    out_base = AW'(x.ob);
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // a second start mid-job must be ignored
  task automatic wait_done(output int cnt);
    cnt = 1;
    while (!done && cnt < 5000) begin
      step();
      cnt++;
      start = (cnt == 20);
    end
    start = 1'b0;
    chk("done_seen", done, 1);
  endtask

  task automatic run(vec_t x, bit pp, output int cnt);
    int r0 = n_rd, w0 = n_wr, d0 = n_done, c0 = n_coinc;
    load(x);
    hold_wr = pp;
    launch(x);
    if (pp) begin
      repeat (30) step();
      chk("pp_reads", n_rd - r0, 2);
      chk("pp_blocked", rd_cmd_valid, 0);
      hold_wr = 0;
    end
    wait_done(cnt);
    if (pp) chk("pp_coincide", n_coinc > c0, 1);
    repeat (3) step();
    chk("reads", n_rd - r0, x.nt);
    chk("writes", n_wr - w0, x.nt);
    chk("done_pulses", n_done - d0, 1);
    chk("idle_busy", busy, 0);
    chk("rd_q_empty", rd_q.size(), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cnt, r0, d0, k;
    v[0] = '{197, 6, 197 * 32, 32'h1000_0000, 32'h2000_0000, 0, 42};
    v[1] = '{197, 6, 197 * 32, 32'h1000_0000, 32'h2000_0000, 1, 42};
    v[2] = '{33, 1, 64, 32'h100, 32'h8000, 0, 2};
    v[3] = '{32, 3, 1024, 32'h40, 32'h0, 1, 3};
    v[4] = '{0, 4, 64, 0, 0, 0, 0};
    v[5] = '{5, 0, 64, 0, 0, 0, 0};
    v[6] = '{100, 2, 4000, 32'hFFFF_F000, 32'h10, 1, 8};
    repeat (3) step();
    rst = 1'b0;
    step();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rd_valid", rd_cmd_valid, 0);
    chk("rst_wr_valid", wr_cmd_valid, 0);
    rd_due.push_back(0);
    wr_due.push_back(0);
    repeat (3) step();
    chk("idle_pulse_busy", busy, 0);
    chk("idle_pulse_wr_valid", wr_cmd_valid, 0);
    for (int i = 0; i < 7; i++) begin
      rd_log.delete();
      len_log.delete();
      run(v[i], 0, cnt);
      if (v[i].nt == 0) chk("empty_latency", cnt, 2);
      if (i == 0) begin
        chk("tile1_addr", rd_log[1], 32'h1000_0000 + 6304);
        chk("tile6_addr", rd_log[6], 32'h1000_0000 + 1024);
        chk("tile35_len", len_log[35], 31);
        chk("tile36_len", len_log[36], 4);
        chk("tile41_len", len_log[41], 4);
      end
    end
    run(v[0], 1, cnt);
    // abort after five reads, then a clean rerun must start from tile 0 / buf 0
    load(v[0]);
    r0 = n_rd;
    d0 = n_done;
    launch(v[0]);
    k = 0;
    while (n_rd - r0 < 5 && k < 200) begin
      step();
      k++;
    end
    chk("abort_reads", n_rd - r0, 5);
    step();
    rst = 1'b1;
    step();
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_rd_valid", rd_cmd_valid, 0);
    chk("abort_wr_valid", wr_cmd_valid, 0);
    rst = 1'b0;
    rd_q.delete();
    wr_q.delete();
    rd_due.delete();
    wr_due.delete();
    repeat (5) step();
    chk("abort_no_done", n_done - d0, 0);
    run(v[0], 0, cnt);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
